counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Consumer-side monitor for the dual 4-bit counter outputs produced by the counters block.
- Samples counter1 and counter2 every clock and checks each against a fixed per-cycle step, with modulo 2^WIDTH wrap.
- Acquires lock on both streams, then reports step errors and counts errors and wraps.
- Sits beside the counters block in simulation and on-chip self-test, replacing eyeball checks of waveforms.

Parameters:
- WIDTH, 4, width of each observed counter bus.
- STEP1, 1, expected signed per-cycle increment of counter1, applied modulo 2^WIDTH.
- STEP2, 1, expected signed per-cycle increment of counter2, applied modulo 2^WIDTH.
- LOCK_CNT, 2, consecutive correct steps on both streams required to lock; legal range 1..15.
- CNT_W, 8, width of the error and wrap counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- enable  in  1  checking enabled; when low, FSM holds IDLE.
- clear  in  1  synchronous clear of err_count, wrap1_count and wrap2_count.
- counter1  in  WIDTH  observed counter stream 1.
- counter2  in  WIDTH  observed counter stream 2.
- locked  out  1  both streams are tracking the expected step.
- err1  out  1  one-cycle pulse: counter1 step mismatch while locked.
- err2  out  1  one-cycle pulse: counter2 step mismatch while locked.
- err_count  out  CNT_W  saturating count of error events.
- wrap1_count  out  CNT_W  saturating count of counter1 wraps seen while locked.
- wrap2_count  out  CNT_W  saturating count of counter2 wraps seen while locked.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs and internal registers go to 0.
  - FSM goes to IDLE.
  - Outputs stay 0 until the first rising edge after reset returns to 1.
- Definitions:
  - prevN is the sample registered at the previous edge.
  - expN = (prevN + STEPN) mod 2^WIDTH.
  - matchN = (counterN == expN).
  - Both match = match1 & match2.
- FSM states: IDLE, FIRST, ACQUIRE, LOCKED.
- IDLE:
  - Entered on reset, or on any edge where enable=0.
  - Internal state: match counter cleared, prev registers not updated.
  - Outputs: locked=0; counters hold their values.
  - Exit: enable=1 goes to FIRST.
- FIRST:
  - Capture prev1/prev2 and go to ACQUIRE.
  - No comparison is made.
- ACQUIRE:
  - Every edge: capture prev registers and compare.
  - Both match: match counter increments; when it reaches LOCK_CNT, go to LOCKED and set locked=1 at that same edge.
  - Any mismatch: match counter returns to 0; no error is flagged.
- LOCKED:
  - Every edge: capture prev registers and compare.
  - On mismatch of stream N: errN=1 for exactly one cycle, err_count += 1, locked=0, FSM goes to ACQUIRE with match counter 0.
  - If both streams mismatch on the same edge: err1=err2=1, and err_count increments by 1, not 2.
- Latency:
  - err1/err2/locked are registered.
  - A bad sample present before edge K is reported on the outputs immediately after edge K.
- Wrap detection (LOCKED only, on a matched step):
  - STEPN>0: counterN < prevN (unsigned).
  - STEPN<0: counterN > prevN.
  - STEPN=0: never a wrap.
  - On a wrap, wrapN_count += 1.
- Counter arithmetic:
  - All counters saturate at 2^CNT_W-1 and never roll over.
  - The match counter saturates at LOCK_CNT.
- clear:
  - Zeroes err_count, wrap1_count and wrap2_count at the edge.
  - Does not change FSM state, locked, or the prev registers.
  - If an increment is pending on the same edge, clear wins and the result is 0.
- enable dropping in any state:
  - Next edge goes to IDLE with locked=0.
  - A mismatch on that same edge is not flagged.
- Reset asserted mid-operation: immediate return to reset values, irrespective of the clock.

Test Plan:
- Reset then lock:
  - Stimulus: hold reset=0 for 2 clks, release, enable=1, drive counter1=counter2=0,1,2,3,4 (defaults).
  - Required: locked=1 after the 3rd sample edge (FIRST + 2 matches); err_count=0.
- Wrap:
  - Stimulus: locked streams run 14,15,0,1.
  - Required: wrap1_count=wrap2_count=1; no err pulses.
- Single-stream glitch:
  - Stimulus: while locked, counter1 goes 5,6,9 and counter2 stays correct.
  - Required: err1=1 for one cycle, err2=0, err_count=1, locked=0.
  - Then 10,11 on both streams gives relock (locked=1) two edges later.
- Dual mismatch:
  - Stimulus: both streams jump on the same edge.
  - Required: err1=err2=1 together, err_count increments by exactly 1.
- Clear and saturation:
  - Stimulus: with CNT_W=2, force 5 error events.
  - Required: err_count=3 (saturated).
  - Then assert clear on an edge that also carries an error: err_count=0.
- Async reset and enable:
  - Stimulus: pull reset low between clock edges while locked.
  - Required: outputs go to 0 immediately.
  - Stimulus: enable=0 for one cycle.
  - Required: locked=0; counts retained.

Source files
------------

// File: rtl/counter_checker_if.sv
// -----------------------------------------------------------------------------
// counter_checker_if
// Bundles the observed counter streams, the checker controls and the checker
// status outputs into one connection between the stimulus/consumer side and
// counter_checker.
//
// Signals:
//   enable       checking enabled (driven by master)
//   clear        synchronous clear of the event counters (driven by master)
//   counter1/2   observed counter streams, WIDTH bits (driven by master)
//   locked       both streams tracking the expected step (driven by slave)
//   err1/err2    one-cycle step-mismatch pulses (driven by slave)
//   err_count    saturating error-event count, CNT_W bits (driven by slave)
//   wrap1_count  saturating counter1 wrap count, CNT_W bits (driven by slave)
//   wrap2_count  saturating counter2 wrap count, CNT_W bits (driven by slave)
//
// Modports:
//   master  the side that produces the streams and reads the status
//   slave   the checker itself
// -----------------------------------------------------------------------------
interface counter_checker_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             enable;
   logic             clear;
   logic [WIDTH-1:0] counter1;
   logic [WIDTH-1:0] counter2;
   logic             locked;
   logic             err1;
   logic             err2;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] wrap1_count;
   logic [CNT_W-1:0] wrap2_count;

   modport master (
      output enable, clear, counter1, counter2,
      input  locked, err1, err2, err_count, wrap1_count, wrap2_count
   );

   modport slave (
      input  enable, clear, counter1, counter2,
      output locked, err1, err2, err_count, wrap1_count, wrap2_count
   );
endinterface

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
// Consumer-side monitor for two free-running counter streams. Every clock the
// current sample of each stream is compared with the previous sample plus a
// fixed signed step (modulo 2^WIDTH). After LOCK_CNT consecutive correct steps
// on both streams the checker locks; while locked, step mismatches produce
// one-cycle error pulses and bump a saturating error counter, and correct
// steps that wrap around bump per-stream saturating wrap counters.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous reset, active low
//   bus    counter_checker_if.slave:
//            in : enable, clear, counter1, counter2
//            out: locked, err1, err2, err_count, wrap1_count, wrap2_count
// -----------------------------------------------------------------------------
module counter_checker #(
   parameter int WIDTH    = 4,
   parameter int STEP1    = 1,
   parameter int STEP2    = 1,
   parameter int LOCK_CNT = 2,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   counter_checker_if.slave  bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FIRST  = 2'd1;
   localparam logic [1:0] S_ACQ    = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   // Steps folded into WIDTH bits: adding the two's-complement pattern gives
   // the modulo-2^WIDTH step for negative STEP values too.
   localparam logic [WIDTH-1:0] STEP1_W  = WIDTH'(STEP1);
   localparam logic [WIDTH-1:0] STEP2_W  = WIDTH'(STEP2);
   localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] prev1_q, prev1_d;
   logic [WIDTH-1:0] prev2_q, prev2_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic             locked_q, locked_d;
   logic             err1_q, err1_d;
   logic             err2_q, err2_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] wrap1_q, wrap1_d;
   logic [CNT_W-1:0] wrap2_q, wrap2_d;

   logic [WIDTH-1:0] exp1, exp2;
   logic             match1, match2;
   logic             wrap1_hit, wrap2_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // A wrap is a correct step whose unsigned value moved "backwards" relative
   // to the step direction; a zero step never wraps.
   function automatic logic wrap_seen(input int step,
                                      input logic [WIDTH-1:0] cur,
                                      input logic [WIDTH-1:0] prv);
      if (step > 0)      return cur < prv;
      else if (step < 0) return cur > prv;
      else               return 1'b0;
   endfunction

   always_comb begin
      exp1      = prev1_q + STEP1_W;
      exp2      = prev2_q + STEP2_W;
      match1    = (bus.counter1 == exp1);
      match2    = (bus.counter2 == exp2);
      wrap1_hit = wrap_seen(STEP1, bus.counter1, prev1_q);
      wrap2_hit = wrap_seen(STEP2, bus.counter2, prev2_q);
   end

   always_comb begin
      state_d     = state_q;
      prev1_d     = prev1_q;
      prev2_d     = prev2_q;
      match_cnt_d = match_cnt_q;
      locked_d    = locked_q;
      err1_d      = 1'b0;
      err2_d      = 1'b0;
      err_cnt_d   = err_cnt_q;
      wrap1_d     = wrap1_q;
      wrap2_d     = wrap2_q;

      if (!bus.enable) begin
         // Disabling overrides everything, including a mismatch on this edge.
         state_d     = S_IDLE;
         locked_d    = 1'b0;
         match_cnt_d = 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d     = S_FIRST;
               match_cnt_d = 4'd0;
            end

            S_FIRST: begin
               prev1_d = bus.counter1;
               prev2_d = bus.counter2;
               state_d = S_ACQ;
            end

            S_ACQ: begin
               prev1_d = bus.counter1;
               prev2_d = bus.counter2;
               if (match1 && match2) begin
                  if (match_cnt_q + 4'd1 >= LOCK_MAX) begin
                     match_cnt_d = LOCK_MAX;
                     state_d     = S_LOCKED;
                     locked_d    = 1'b1;
                  end else begin
                     match_cnt_d = match_cnt_q + 4'd1;
                  end
               end else begin
                  match_cnt_d = 4'd0;
               end
            end

            S_LOCKED: begin
               prev1_d = bus.counter1;
               prev2_d = bus.counter2;
               if (match1 && wrap1_hit) wrap1_d = sat_inc(wrap1_q);
               if (match2 && wrap2_hit) wrap2_d = sat_inc(wrap2_q);
               if (!(match1 && match2)) begin
                  // A dual mismatch is one error event, hence a single increment.
                  err1_d      = !match1;
                  err2_d      = !match2;
                  err_cnt_d   = sat_inc(err_cnt_q);
                  locked_d    = 1'b0;
                  state_d     = S_ACQ;
                  match_cnt_d = 4'd0;
               end
            end

            default: begin
               state_d     = S_IDLE;
               locked_d    = 1'b0;
               match_cnt_d = 4'd0;
            end
         endcase
      end

      // Clear wins over any increment computed on the same edge.
      if (bus.clear) begin
         err_cnt_d = '0;
         wrap1_d   = '0;
         wrap2_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         prev1_q     <= '0;
         prev2_q     <= '0;
         match_cnt_q <= 4'd0;
         locked_q    <= 1'b0;
         err1_q      <= 1'b0;
         err2_q      <= 1'b0;
         err_cnt_q   <= '0;
         wrap1_q     <= '0;
         wrap2_q     <= '0;
      end else begin
         state_q     <= state_d;
         prev1_q     <= prev1_d;
         prev2_q     <= prev2_d;
         match_cnt_q <= match_cnt_d;
         locked_q    <= locked_d;
         err1_q      <= err1_d;
         err2_q      <= err2_d;
         err_cnt_q   <= err_cnt_d;
         wrap1_q     <= wrap1_d;
         wrap2_q     <= wrap2_d;
      end
   end

   assign bus.locked      = locked_q;
   assign bus.err1        = err1_q;
   assign bus.err2        = err2_q;
   assign bus.err_count   = err_cnt_q;
   assign bus.wrap1_count = wrap1_q;
   assign bus.wrap2_count = wrap2_q;

endmodule

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
// Two checker instances: A uses the default steps with CNT_W=2 so that counter
// saturation is reachable; B uses STEP1=-3, STEP2=0, LOCK_CNT=3, CNT_W=8 to
// exercise negative and zero steps. A driver applies inputs on the falling
// edge, advances a behavioural model of the checking rules and queues the
// expected outputs; a monitor pops and compares just after each rising edge.
// -----------------------------------------------------------------------------
module tb_counter_checker;

   typedef struct {
      int locked;
      int err1;
      int err2;
      int errc;
      int w1;
      int w2;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   counter_checker_if #(.WIDTH(4), .CNT_W(2)) ifa ();
   counter_checker_if #(.WIDTH(4), .CNT_W(8)) ifb ();

   counter_checker #(.WIDTH(4), .STEP1(1), .STEP2(1), .LOCK_CNT(2), .CNT_W(2)) dut_a (
      .clk(clk), .reset(rst_n), .bus(ifa)
   );

   counter_checker #(.WIDTH(4), .STEP1(-3), .STEP2(0), .LOCK_CNT(3), .CNT_W(8)) dut_b (
      .clk(clk), .reset(rst_n), .bus(ifb)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   exp_t qa[$];
   exp_t qb[$];

   // Behavioural model state, index 0 = instance A, 1 = instance B.
   int m_age[2];     // consecutive enabled edges seen (0 = idle)
   int m_lock[2];
   int m_run[2];
   int m_p1[2];
   int m_p2[2];
   int m_e1[2];
   int m_e2[2];
   int m_ec[2];
   int m_w1[2];
   int m_w2[2];

   // Stream generators: A1, A2, B1, B2.
   int g[4];

   function automatic int mod16(input int v);
      return ((v % 16) + 16) % 16;
   endfunction

   function automatic int step1_of(input int k); return (k == 0) ? 1 : -3; endfunction
   function automatic int step2_of(input int k); return (k == 0) ? 1 : 0;  endfunction
   function automatic int lock_of(input int k);  return (k == 0) ? 2 : 3;  endfunction
   function automatic int cmax_of(input int k);  return (k == 0) ? 3 : 255; endfunction
   function automatic int gstep(input int i);    return (i < 2) ? 1 : ((i == 2) ? -3 : 0); endfunction

   function automatic int sat(input int k, input int v);
      return (v + 1 > cmax_of(k)) ? cmax_of(k) : v + 1;
   endfunction

   function automatic bit wraps(input int s, input int p, input int c);
      if (s > 0) return c < p;
      if (s < 0) return c > p;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_age[k] = 0; m_lock[k] = 0; m_run[k] = 0; m_p1[k] = 0; m_p2[k] = 0;
      m_e1[k] = 0; m_e2[k] = 0; m_ec[k] = 0; m_w1[k] = 0; m_w2[k] = 0;
   endtask

   task automatic model_edge(input int k, input bit en, input bit clr, input int c1, input int c2);
      bit ok1, ok2;
      m_e1[k] = 0;
      m_e2[k] = 0;
      if (!en) begin
         m_age[k] = 0; m_lock[k] = 0; m_run[k] = 0;
      end else if (m_age[k] == 0) begin
         m_age[k] = 1;
      end else if (m_age[k] == 1) begin
         m_p1[k] = c1; m_p2[k] = c2; m_age[k] = 2;
      end else begin
         ok1 = (c1 == mod16(m_p1[k] + step1_of(k)));
         ok2 = (c2 == mod16(m_p2[k] + step2_of(k)));
         if (m_lock[k] != 0) begin
            if (ok1 && wraps(step1_of(k), m_p1[k], c1)) m_w1[k] = sat(k, m_w1[k]);
            if (ok2 && wraps(step2_of(k), m_p2[k], c2)) m_w2[k] = sat(k, m_w2[k]);
            if (!(ok1 && ok2)) begin
               m_e1[k] = !ok1; m_e2[k] = !ok2;
               m_ec[k] = sat(k, m_ec[k]);
               m_lock[k] = 0; m_run[k] = 0;
            end
         end else if (ok1 && ok2) begin
            m_run[k]++;
            if (m_run[k] >= lock_of(k)) begin
               m_run[k] = lock_of(k); m_lock[k] = 1;
            end
         end else begin
            m_run[k] = 0;
         end
         m_p1[k] = c1; m_p2[k] = c2;
      end
      if (clr) begin
         m_ec[k] = 0; m_w1[k] = 0; m_w2[k] = 0;
      end
   endtask

   function automatic exp_t snap(input int k);
      exp_t e;
      e.locked = m_lock[k]; e.err1 = m_e1[k]; e.err2 = m_e2[k];
      e.errc = m_ec[k]; e.w1 = m_w1[k]; e.w2 = m_w2[k];
      return e;
   endfunction

   function automatic int next_gen(input int i);
      if ($urandom_range(0, 11) == 0) g[i] = int'($urandom_range(0, 15));
      else g[i] = mod16(g[i] + gstep(i));
      return g[i];
   endfunction

   // One clock of stimulus: A streams given explicitly, B streams generated.
   task automatic cycle(input bit rst_v, input bit en, input bit clr, input int a1, input int a2);
      int b1, b2;
      @(negedge clk);
      b1 = next_gen(2);
      b2 = next_gen(3);
      rst_n = rst_v;
      ifa.enable = en; ifa.clear = clr;
      ifa.counter1 = 4'(a1); ifa.counter2 = 4'(a2);
      ifb.enable = en; ifb.clear = clr;
      ifb.counter1 = 4'(b1); ifb.counter2 = 4'(b2);
      if (!rst_v) begin
         model_reset(0); model_reset(1);
      end else begin
         model_edge(0, en, clr, a1, a2);
         model_edge(1, en, clr, b1, b2);
      end
      qa.push_back(snap(0));
      qb.push_back(snap(1));
   endtask

   task automatic run_a(input int start, input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, mod16(start + i), mod16(start + i));
   endtask

   // Reset asserted between clock edges must clear the outputs at once.
   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_a_locked", int'(ifa.locked), 0);
      chk("async_a_err1", int'(ifa.err1), 0);
      chk("async_a_err2", int'(ifa.err2), 0);
      chk("async_a_errc", int'(ifa.err_count), 0);
      chk("async_a_wrap1", int'(ifa.wrap1_count), 0);
      chk("async_a_wrap2", int'(ifa.wrap2_count), 0);
      chk("async_b_locked", int'(ifb.locked), 0);
      chk("async_b_errc", int'(ifb.err_count), 0);
      chk("async_b_wrap1", int'(ifb.wrap1_count), 0);
      model_reset(0);
      model_reset(1);
   endtask

   task automatic cmp(input string tag, input exp_t e, input int lk, input int e1,
                      input int e2, input int ec, input int w1, input int w2);
      chk({tag, "_locked"}, lk, e.locked);
      chk({tag, "_err1"}, e1, e.err1);
      chk({tag, "_err2"}, e2, e.err2);
      chk({tag, "_err_count"}, ec, e.errc);
      chk({tag, "_wrap1_count"}, w1, e.w1);
      chk({tag, "_wrap2_count"}, w2, e.w2);
   endtask

   // Monitor: outputs are registered, so they are sampled just after the edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         cmp("a", e, int'(ifa.locked), int'(ifa.err1), int'(ifa.err2),
             int'(ifa.err_count), int'(ifa.wrap1_count), int'(ifa.wrap2_count));
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         cmp("b", e, int'(ifb.locked), int'(ifb.err1), int'(ifb.err2),
             int'(ifb.err_count), int'(ifb.wrap1_count), int'(ifb.wrap2_count));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected stimulus to complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      ifa.enable = 1'b0; ifa.clear = 1'b0; ifa.counter1 = '0; ifa.counter2 = '0;
      ifb.enable = 1'b0; ifb.clear = 1'b0; ifb.counter1 = '0; ifb.counter2 = '0;
      for (int i = 0; i < 4; i++) g[i] = 0;
      model_reset(0);
      model_reset(1);

      // Reset held for two clocks, then lock on 0,1,2,... after one lead edge.
      cycle(1'b0, 1'b0, 1'b0, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 0, 0);
      cycle(1'b1, 1'b1, 1'b0, 15, 15);
      run_a(0, 5);

      // Run through 14,15,0,1: one wrap per stream.
      run_a(5, 13);

      // Single-stream glitch on counter1, then relock.
      run_a(2, 5);
      cycle(1'b1, 1'b1, 1'b0, 9, 7);
      cycle(1'b1, 1'b1, 1'b0, 10, 8);
      cycle(1'b1, 1'b1, 1'b0, 11, 9);
      cycle(1'b1, 1'b1, 1'b0, 12, 10);

      // Both streams jump on the same edge.
      cycle(1'b1, 1'b1, 1'b0, 3, 0);
      run_a(1, 4);

      // Five error events saturate the 2-bit error count.
      for (int n = 0; n < 5; n++) begin
         run_a(0, 4);
         cycle(1'b1, 1'b1, 1'b0, 9, 9);
      end
      // Clear on an edge that also carries an error.
      run_a(0, 4);
      cycle(1'b1, 1'b1, 1'b1, 9, 3);

      // Asynchronous reset while locked.
      run_a(5, 5);
      async_reset();
      cycle(1'b1, 1'b1, 1'b0, 0, 0);
      run_a(0, 20);

      // Enable low for one cycle: unlock, counts retained.
      cycle(1'b1, 1'b0, 1'b0, 8, 8);
      run_a(9, 6);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 249) == 0) async_reset();
         cycle($urandom_range(0, 199) != 0, $urandom_range(0, 19) != 0,
               $urandom_range(0, 39) == 0, next_gen(0), next_gen(1));
      end

      @(posedge clk);
      @(posedge clk);
      #2;
      chk("queue_drain", qa.size() + qb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
